// File: rtl/siu_dmu_out_sched.sv
// SIU->DMU outbound scheduler: round-robin between two sources, serialises each packet
// as one header plus optional four payload beats, and tracks DMU packet credits.
module siu_dmu_out_sched #(
  parameter int CREDITS = 8,
  parameter int CW      = 4
) (
  input  logic           iol2clk,
  input  logic           rst_l,
  input  logic           sched_en,
  input  logic           req0_vld,
  input  logic [127:0]   req0_hdr,
  input  logic           req0_has_data,
  input  logic [511:0]   req0_pay,
  output logic           req0_ack,
  input  logic           req1_vld,
  input  logic [127:0]   req1_hdr,
  input  logic           req1_has_data,
  input  logic [511:0]   req1_pay,
  output logic           req1_ack,
  input  logic           dmu_sio_credit_ret,
  output logic           sio_dmu_hdr_vld,
  output logic           sio_dmu_datareq,
  output logic [127:0]   sio_dmu_data,
  output logic [7:0]     sio_dmu_parity,
  output logic           credit_err,
  output logic           sched_busy
);

  typedef enum logic {ST_IDLE = 1'b0, ST_PAY = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic            sel_q, sel_d;
  logic            last_gnt_q, last_gnt_d;
  logic [CW-1:0]   credits_q, credits_d;
  logic            hdr_vld_q, hdr_vld_d;
  logic            datareq_q, datareq_d;
  logic [127:0]    data_q, data_d;
  logic [7:0]      parity_q, parity_d;
  logic            credit_err_q, credit_err_d;

  logic            grant_s;
  logic            win_s;
  logic [127:0]    win_hdr_s;
  logic            win_has_data_s;
  logic [511:0]    sel_pay_s;
  logic [127:0]    beat_s;
  logic            pay_done_s;
  logic            credit_full_s;

  function automatic logic [7:0] lane_parity(input logic [127:0] word);
    logic [7:0] p;
    p = 8'd0;
    for (int i = 0; i < 8; i++) begin
      p[i] = ^word[16*i +: 16];
    end
    return p;
  endfunction

  assign credit_full_s = (credits_q == CW'(CREDITS));
  assign sel_pay_s     = sel_q ? req1_pay : req0_pay;
  assign beat_s        = sel_pay_s[{bcnt_q, 7'd0} +: 128];

  // Arbitration: a lone requester wins; on a tie the source not granted last time wins.
  always_comb begin
    win_s          = 1'b0;
    win_hdr_s      = req0_hdr;
    win_has_data_s = req0_has_data;
    if (req0_vld && req1_vld) begin
      win_s = ~last_gnt_q;
    end else if (req1_vld) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    if (win_s) begin
      win_hdr_s      = req1_hdr;
      win_has_data_s = req1_has_data;
    end else begin
      win_hdr_s      = req0_hdr;
      win_has_data_s = req0_has_data;
    end
  end

  // rst_l gating keeps acks quiet during a synchronous reset cycle.
  assign grant_s    = rst_l && (state_q == ST_IDLE) && sched_en &&
                      (credits_q != '0) && (req0_vld || req1_vld);
  assign pay_done_s = rst_l && (state_q == ST_PAY) && (bcnt_q == 2'd3);

  assign req0_ack = (grant_s && !win_s && !win_has_data_s) || (pay_done_s && !sel_q);
  assign req1_ack = (grant_s &&  win_s && !win_has_data_s) || (pay_done_s &&  sel_q);

  // Next-state: FSM, beat counter, latched winner and round-robin pointer.
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    sel_d      = sel_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_s) begin
          last_gnt_d = win_s;
          sel_d      = win_s;
          bcnt_d     = 2'd0;
          if (win_has_data_s) begin
            state_d = ST_PAY;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PAY: begin
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PAY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        bcnt_d  = 2'd0;
      end
    endcase
  end

  // Output datapath: header on grant, payload beat during PAY, zeros otherwise.
  always_comb begin
    hdr_vld_d = 1'b0;
    datareq_d = 1'b0;
    data_d    = 128'd0;
    parity_d  = 8'd0;
    if (grant_s) begin
      hdr_vld_d = 1'b1;
      datareq_d = win_has_data_s;
      data_d    = win_hdr_s;
      parity_d  = 8'd0;
    end else if (state_q == ST_PAY) begin
      hdr_vld_d = 1'b0;
      datareq_d = 1'b0;
      data_d    = beat_s;
      parity_d  = lane_parity(beat_s);
    end else begin
      hdr_vld_d = 1'b0;
      datareq_d = 1'b0;
      data_d    = 128'd0;
      parity_d  = 8'd0;
    end
  end

  // Credit counter: a return at full saturates and flags an error.
  always_comb begin
    credits_d    = credits_q;
    credit_err_d = dmu_sio_credit_ret && credit_full_s;
    if (grant_s && !dmu_sio_credit_ret) begin
      credits_d = credits_q - CW'(1);
    end else if (!grant_s && dmu_sio_credit_ret && !credit_full_s) begin
      credits_d = credits_q + CW'(1);
    end else begin
      credits_d = credits_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge iol2clk) begin
    if (!rst_l) begin
      state_q      <= ST_IDLE;
      bcnt_q       <= 2'd0;
      sel_q        <= 1'b0;
      last_gnt_q   <= 1'b1;
      credits_q    <= CW'(CREDITS);
      hdr_vld_q    <= 1'b0;
      datareq_q    <= 1'b0;
      data_q       <= 128'd0;
      parity_q     <= 8'd0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      sel_q        <= sel_d;
      last_gnt_q   <= last_gnt_d;
      credits_q    <= credits_d;
      hdr_vld_q    <= hdr_vld_d;
      datareq_q    <= datareq_d;
      data_q       <= data_d;
      parity_q     <= parity_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign sio_dmu_hdr_vld = hdr_vld_q;
  assign sio_dmu_datareq = datareq_q;
  assign sio_dmu_data    = data_q;
  assign sio_dmu_parity  = parity_q;
  assign credit_err      = credit_err_q;
  assign sched_busy      = (state_q == ST_PAY);

endmodule
